// File: rtl/pong_pkg.sv
// Shared Pong types, default geometry and the paddle step helper.
// The engine and the bench testbench scenarios override timing through module parameters.
package pong_pkg;

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    PLAY  = 2'd1,
    OVER  = 2'd2
  } state_t;

  localparam int DEF_TICK_DIV    = 833333;
  localparam int DEF_SCR_W       = 640;
  localparam int DEF_SCR_H       = 480;
  localparam int DEF_BALL_SZ     = 8;
  localparam int DEF_PAD_H       = 80;
  localparam int DEF_PAD_W       = 8;
  localparam int DEF_PAD_E_X     = 16;
  localparam int DEF_PAD_D_X     = 616;
  localparam int DEF_PAD_SPD     = 4;
  localparam int DEF_BALL_SPD    = 2;
  localparam int DEF_SERVE_TICKS = 60;
  localparam int DEF_MAX_SCORE   = 9;

  // Button bits are laid out as {right down, right up, left down, left up}.
  localparam int BTN_E_UP = 0;
  localparam int BTN_E_DN = 1;
  localparam int BTN_D_UP = 2;
  localparam int BTN_D_DN = 3;

  // One paddle step: up-only or down-only moves and saturates, anything else holds.
  function automatic logic [9:0] pad_move(
    input logic [9:0] y,
    input logic       up,
    input logic       dn,
    input logic [9:0] spd,
    input logic [9:0] y_max
  );
    logic [9:0] y_new;
    y_new = y;
    if (up && !dn) begin
      y_new = (y < spd) ? 10'd0 : y - spd;
    end else if (dn && !up) begin
      y_new = (y > y_max - spd) ? y_max : y + spd;
    end
    return y_new;
  endfunction

endpackage

// File: rtl/pong_tick_gen.sv
// Physics tick generator: free-running divider that pulses o_tick for one
// cycle each time it wraps from TICK_DIV-1 back to 0.
module pong_tick_gen #(
  parameter int TICK_DIV = pong_pkg::DEF_TICK_DIV
) (
  input  logic i_clk,
  input  logic i_srst,
  output logic o_tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == LAST) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
      r_tick <= 1'b0;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/pong_game_engine.sv
// Pong physics and game sequencing: paddles, ball, bounces, scoring and
// the SERVE/PLAY/OVER flow, all advanced once per frame tick.
module pong_game_engine
  import pong_pkg::*;
#(
  parameter int TICK_DIV    = DEF_TICK_DIV,
  parameter int SCR_W       = DEF_SCR_W,
  parameter int SCR_H       = DEF_SCR_H,
  parameter int BALL_SZ     = DEF_BALL_SZ,
  parameter int PAD_H       = DEF_PAD_H,
  parameter int PAD_W       = DEF_PAD_W,
  parameter int PAD_E_X     = DEF_PAD_E_X,
  parameter int PAD_D_X     = DEF_PAD_D_X,
  parameter int PAD_SPD     = DEF_PAD_SPD,
  parameter int BALL_SPD    = DEF_BALL_SPD,
  parameter int SERVE_TICKS = DEF_SERVE_TICKS,
  parameter int MAX_SCORE   = DEF_MAX_SCORE
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic [3:0] buttons_export,
  output logic [9:0] bola_x,
  output logic [9:0] bola_y,
  output logic [9:0] barra_e_y,
  output logic [9:0] barra_d_y,
  output logic [3:0] score_e,
  output logic [3:0] score_d,
  output logic       game_over,
  output logic       frame_tick
);

  localparam int SCW = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;

  localparam logic [9:0] CTR_X     = 10'((SCR_W - BALL_SZ) / 2);
  localparam logic [9:0] CTR_Y     = 10'((SCR_H - BALL_SZ) / 2);
  localparam logic [9:0] PAD_Y0    = 10'((SCR_H - PAD_H) / 2);
  localparam logic [9:0] PAD_Y_MAX = 10'(SCR_H - PAD_H);
  localparam logic [9:0] Y_MAX     = 10'(SCR_H - BALL_SZ);
  localparam logic [9:0] X_AT_E    = 10'(PAD_E_X + PAD_W);
  localparam logic [9:0] X_AT_D    = 10'(PAD_D_X - BALL_SZ);
  localparam logic [3:0] SCORE_END = 4'(MAX_SCORE);

  localparam logic signed [10:0] S_SPD    = 11'(BALL_SPD);
  localparam logic signed [10:0] S_BALL   = 11'(BALL_SZ);
  localparam logic signed [10:0] S_X_MAX  = 11'(SCR_W - BALL_SZ);
  localparam logic signed [10:0] S_Y_MAX  = 11'(SCR_H - BALL_SZ);
  localparam logic signed [10:0] S_E_FACE = 11'(PAD_E_X + PAD_W);
  localparam logic signed [10:0] S_E_BACK = 11'(PAD_E_X);
  localparam logic signed [10:0] S_D_FACE = 11'(PAD_D_X);
  localparam logic signed [10:0] S_D_BACK = 11'(PAD_D_X + PAD_W);

  logic [3:0]     r_btn_meta;
  logic [3:0]     r_btn_sync;
  logic [9:0]     r_bola_x;
  logic [9:0]     r_bola_y;
  logic [9:0]     r_barra_e_y;
  logic [9:0]     r_barra_d_y;
  logic [3:0]     r_score_e;
  logic [3:0]     r_score_d;
  logic           r_vx_neg;
  logic           r_vy_neg;
  state_t         r_state;
  logic [SCW-1:0] r_serve_cnt;
  logic           r_game_over;

  logic           w_frame_tick;
  logic [3:0]     w_pressed;
  logic [9:0]     w_pad_y    [2];
  logic [9:0]     w_pad_next [2];

  pong_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .i_clk  (clk_clk),
    .i_srst (reset_reset),
    .o_tick (w_frame_tick)
  );

  // KEYs are active-low; after synchronizing, a 1 means pressed.
  assign w_pressed  = ~r_btn_sync;
  assign w_pad_y[0] = r_barra_e_y;
  assign w_pad_y[1] = r_barra_d_y;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_pad
      assign w_pad_next[gi] = pad_move(w_pad_y[gi],
                                       w_pressed[BTN_E_UP + 2 * gi],
                                       w_pressed[BTN_E_DN + 2 * gi],
                                       10'(PAD_SPD), PAD_Y_MAX);
    end
  endgenerate

  logic signed [10:0] w_vx;
  logic signed [10:0] w_vy;
  logic signed [10:0] w_nx;
  logic signed [10:0] w_ny;
  logic               w_ov_e;
  logic               w_ov_d;
  logic               w_hit_e;
  logic               w_hit_d;
  logic               w_miss_e;
  logic               w_miss_d;

  assign w_vx = r_vx_neg ? -S_SPD : S_SPD;
  assign w_vy = r_vy_neg ? -S_SPD : S_SPD;
  assign w_nx = $signed({1'b0, r_bola_x}) + w_vx;
  assign w_ny = $signed({1'b0, r_bola_y}) + w_vy;

  // Vertical overlap is judged on the ball and paddle positions before this tick's moves.
  assign w_ov_e = (({1'b0, r_bola_y} + 11'(BALL_SZ)) > {1'b0, r_barra_e_y}) &&
                  ({1'b0, r_bola_y} < ({1'b0, r_barra_e_y} + 11'(PAD_H)));
  assign w_ov_d = (({1'b0, r_bola_y} + 11'(BALL_SZ)) > {1'b0, r_barra_d_y}) &&
                  ({1'b0, r_bola_y} < ({1'b0, r_barra_d_y} + 11'(PAD_H)));

  assign w_hit_e  = r_vx_neg && (w_nx <= S_E_FACE) && ((w_nx + S_BALL) > S_E_BACK) && w_ov_e;
  assign w_hit_d  = !r_vx_neg && ((w_nx + S_BALL) >= S_D_FACE) && (w_nx < S_D_BACK) && w_ov_d;
  assign w_miss_e = (w_nx < 11'sd0);
  assign w_miss_d = (w_nx > S_X_MAX);

  logic [9:0]     w_x_next;
  logic [9:0]     w_y_next;
  logic           w_vx_neg_next;
  logic           w_vy_neg_next;
  logic [3:0]     w_se_next;
  logic [3:0]     w_sd_next;
  state_t         w_state_next;
  logic [SCW-1:0] w_serve_next;

  always_comb begin
    w_x_next      = r_bola_x;
    w_y_next      = r_bola_y;
    w_vx_neg_next = r_vx_neg;
    w_vy_neg_next = r_vy_neg;
    w_se_next     = r_score_e;
    w_sd_next     = r_score_d;
    w_state_next  = r_state;
    w_serve_next  = r_serve_cnt;
    case (r_state)
      SERVE: begin
        w_x_next = CTR_X;
        w_y_next = CTR_Y;
        if (r_serve_cnt == SCW'(SERVE_TICKS - 1)) begin
          w_state_next = PLAY;
          w_serve_next = '0;
        end else begin
          w_serve_next = r_serve_cnt + 1'b1;
        end
      end
      PLAY: begin
        if (w_ny < 11'sd0) begin
          w_y_next      = 10'd0;
          w_vy_neg_next = 1'b0;
        end else if (w_ny > S_Y_MAX) begin
          w_y_next      = Y_MAX;
          w_vy_neg_next = 1'b1;
        end else begin
          w_y_next = w_ny[9:0];
        end
        // A paddle hit wins over a miss computed from the same nx.
        if (w_hit_e) begin
          w_x_next      = X_AT_E;
          w_vx_neg_next = 1'b0;
        end else if (w_hit_d) begin
          w_x_next      = X_AT_D;
          w_vx_neg_next = 1'b1;
        end else if (w_miss_e || w_miss_d) begin
          w_x_next     = CTR_X;
          w_y_next     = CTR_Y;
          w_serve_next = '0;
          if (w_miss_e) begin
            w_sd_next     = r_score_d + 1'b1;
            w_vx_neg_next = 1'b1;
          end else begin
            w_se_next     = r_score_e + 1'b1;
            w_vx_neg_next = 1'b0;
          end
          w_state_next = ((w_sd_next == SCORE_END) || (w_se_next == SCORE_END)) ? OVER : SERVE;
        end else begin
          w_x_next = w_nx[9:0];
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_btn_meta  <= 4'hF;
      r_btn_sync  <= 4'hF;
      r_bola_x    <= CTR_X;
      r_bola_y    <= CTR_Y;
      r_barra_e_y <= PAD_Y0;
      r_barra_d_y <= PAD_Y0;
      r_score_e   <= 4'd0;
      r_score_d   <= 4'd0;
      r_vx_neg    <= 1'b0;
      r_vy_neg    <= 1'b0;
      r_state     <= SERVE;
      r_serve_cnt <= '0;
      r_game_over <= 1'b0;
    end else begin
      r_btn_meta <= buttons_export;
      r_btn_sync <= r_btn_meta;
      if (w_frame_tick) begin
        if (r_state != OVER) begin
          r_barra_e_y <= w_pad_next[0];
          r_barra_d_y <= w_pad_next[1];
        end
        r_bola_x    <= w_x_next;
        r_bola_y    <= w_y_next;
        r_vx_neg    <= w_vx_neg_next;
        r_vy_neg    <= w_vy_neg_next;
        r_score_e   <= w_se_next;
        r_score_d   <= w_sd_next;
        r_state     <= w_state_next;
        r_serve_cnt <= w_serve_next;
        r_game_over <= (w_state_next == OVER);
      end
    end
  end

  assign bola_x     = r_bola_x;
  assign bola_y     = r_bola_y;
  assign barra_e_y  = r_barra_e_y;
  assign barra_d_y  = r_barra_d_y;
  assign score_e    = r_score_e;
  assign score_d    = r_score_d;
  assign game_over  = r_game_over;
  assign frame_tick = w_frame_tick;

endmodule

// File: tb/tb_pong_game_engine.sv
// Randomized Pong bench: a tick-level game model predicts every frame's
// outputs into a queue that an independent monitor drains and compares.
module tb_pong_game_engine;

  localparam int TD = 4;
  localparam int ST = 2;

  logic       clk_clk;
  logic       reset_reset;
  logic [3:0] buttons_export;
  logic [9:0] bola_x, bola_y, barra_e_y, barra_d_y;
  logic [3:0] score_e, score_d;
  logic       game_over, frame_tick;

  pong_game_engine #(
    .TICK_DIV    (TD),
    .SERVE_TICKS (ST)
  ) dut (
    .clk_clk        (clk_clk),
    .reset_reset    (reset_reset),
    .buttons_export (buttons_export),
    .bola_x         (bola_x),
    .bola_y         (bola_y),
    .barra_e_y      (barra_e_y),
    .barra_d_y      (barra_d_y),
    .score_e        (score_e),
    .score_d        (score_d),
    .game_over      (game_over),
    .frame_tick     (frame_tick)
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  typedef struct {
    int bx; int by; int pe; int pd; int se; int sd; int go;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   tick_no = 0;
  bit   done = 0;
  logic [3:0] cur_btn;

  // Game model: mode 0 = waiting to serve, 1 = ball in play, 2 = finished.
  int m_bx, m_by, m_vx, m_vy, m_pe, m_pd, m_se, m_sd, m_mode, m_wait;

  function automatic void model_reset();
    m_bx = 316; m_by = 236; m_vx = 2; m_vy = 2;
    m_pe = 200; m_pd = 200; m_se = 0; m_sd = 0;
    m_mode = 0; m_wait = 0;
  endfunction

  function automatic int pad(input int y, input bit up, input bit dn);
    if (up && !dn) return (y - 4 < 0) ? 0 : y - 4;
    if (dn && !up) return (y + 4 > 400) ? 400 : y + 4;
    return y;
  endfunction

  function automatic void model_step(input logic [3:0] raw);
    int ope, opd, obx, oby, nx, ny;
    if (m_mode == 2) return;
    ope = m_pe; opd = m_pd; obx = m_bx; oby = m_by;
    m_pe = pad(ope, !raw[0], !raw[1]);
    m_pd = pad(opd, !raw[2], !raw[3]);
    if (m_mode == 0) begin
      m_bx = 316; m_by = 236; m_wait++;
      if (m_wait == ST) begin m_mode = 1; m_wait = 0; end
      return;
    end
    ny = oby + m_vy;
    if (ny < 0) begin m_by = 0; m_vy = 2; end
    else if (ny > 472) begin m_by = 472; m_vy = -2; end
    else m_by = ny;
    nx = obx + m_vx;
    if (m_vx < 0 && nx <= 24 && nx + 8 > 16 && oby + 8 > ope && oby < ope + 80) begin
      m_bx = 24; m_vx = 2;
    end else if (m_vx > 0 && nx + 8 >= 616 && nx < 624 && oby + 8 > opd && oby < opd + 80) begin
      m_bx = 608; m_vx = -2;
    end else if (nx < 0 || nx > 632) begin
      if (nx < 0) begin m_sd++; m_vx = -2; end
      else begin m_se++; m_vx = 2; end
      m_bx = 316; m_by = 236; m_wait = 0;
      m_mode = (m_sd == 9 || m_se == 9) ? 2 : 0;
    end else begin
      m_bx = nx;
    end
  endfunction

  // Button strategies: 0 random, 1 left up, 2 left up+down, 3 chase ball, 4 dodge ball.
  function automatic logic [3:0] next_buttons(input int strat);
    logic [3:0] p;
    int tgt;
    p = 4'b0000;
    case (strat)
      0: p = 4'($urandom_range(0, 15));
      1: p = 4'b0001;
      2: p = 4'b0011;
      3: begin
        tgt = m_by - 36;
        p[0] = (m_pe > tgt + 3); p[1] = (m_pe < tgt - 3);
        p[2] = (m_pd > tgt + 3); p[3] = (m_pd < tgt - 3);
      end
      default: begin
        tgt = (m_by < 200) ? 400 : 0;
        p[0] = (m_pe > tgt); p[1] = (m_pe < tgt);
        p[2] = (m_pd > tgt); p[3] = (m_pd < tgt);
      end
    endcase
    return ~p;
  endfunction

  task automatic finish_run();
    if (!done) begin
      done = 1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  endtask

  task automatic check_val(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic check_reset_state();
    check_val("rst_bola_x", int'(bola_x), 316);
    check_val("rst_bola_y", int'(bola_y), 236);
    check_val("rst_barra_e", int'(barra_e_y), 200);
    check_val("rst_barra_d", int'(barra_d_y), 200);
    check_val("rst_scores", int'({score_e, score_d}), 0);
    check_val("rst_flags", int'({game_over, frame_tick}), 0);
  endtask

  task automatic wait_tick();
    int c;
    c = 0;
    @(negedge clk_clk);
    while (!frame_tick && c < 4 * TD) begin
      @(negedge clk_clk);
      c++;
    end
    if (!frame_tick) begin
      checks++; errors++;
      $display("FAIL tick_timeout waited %0d cycles, expected a frame_tick within %0d", c, TD);
      finish_run();
    end
  endtask

  // Caller is on a negedge; reset is held across exactly one rising edge.
  task automatic pulse_reset();
    #1 reset_reset = 1'b1;
    @(posedge clk_clk);
    @(negedge clk_clk);
    #1;
    check_reset_state();
    exp_q.delete();
    reset_reset = 1'b0;
    model_reset();
  endtask

  task automatic run_ticks(input int n, input int strat);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      wait_tick();
      model_step(cur_btn);
      e.bx = m_bx; e.by = m_by; e.pe = m_pe; e.pd = m_pd;
      e.se = m_se; e.sd = m_sd; e.go = (m_mode == 2) ? 1 : 0;
      exp_q.push_back(e);
      @(posedge clk_clk);
      #1;
      cur_btn = next_buttons(strat);
      buttons_export = cur_btn;
    end
  endtask

  // Monitor: pops one expectation per frame and checks the tick period.
  initial begin
    bit prev_tick;
    bit armed;
    int cyc;
    exp_t e;
    prev_tick = 0; armed = 0; cyc = 0;
    forever begin
      @(negedge clk_clk);
      if (prev_tick && !reset_reset) begin
        tick_no++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL frame_%0d no expectation queued for an output update", tick_no);
        end else begin
          e = exp_q.pop_front();
          if (int'(bola_x) != e.bx || int'(bola_y) != e.by || int'(barra_e_y) != e.pe ||
              int'(barra_d_y) != e.pd || int'(score_e) != e.se || int'(score_d) != e.sd ||
              int'(game_over) != e.go) begin
            errors++;
            $display("FAIL frame_%0d got ball=(%0d,%0d) pad=(%0d,%0d) score=%0d:%0d over=%0d expected ball=(%0d,%0d) pad=(%0d,%0d) score=%0d:%0d over=%0d",
                     tick_no, bola_x, bola_y, barra_e_y, barra_d_y, score_e, score_d, game_over,
                     e.bx, e.by, e.pe, e.pd, e.se, e.sd, e.go);
          end else begin
            $display("frame %0d ball=(%0d,%0d) pad=(%0d,%0d) score=%0d:%0d over=%0d",
                     tick_no, bola_x, bola_y, barra_e_y, barra_d_y, score_e, score_d, game_over);
          end
        end
      end
      if (reset_reset) begin
        armed = 0; cyc = 0;
      end else begin
        cyc++;
        if (frame_tick) begin
          if (armed) check_val("tick_period", cyc, TD);
          armed = 1; cyc = 0;
        end
      end
      prev_tick = frame_tick;
    end
  end

  initial begin
    #400000;
    checks++; errors++;
    $display("FAIL watchdog simulation time limit reached");
    finish_run();
  end

  initial begin
    int t;
    reset_reset = 1'b1;
    buttons_export = 4'hF;
    cur_btn = 4'hF;
    model_reset();
    repeat (4) @(posedge clk_clk);
    @(negedge clk_clk);
    #1;
    check_reset_state();
    reset_reset = 1'b0;

    // Serve then first play tick; left-up held from the second tick on.
    run_ticks(3, 1);
    check_val("first_play_x", int'(bola_x), 318);
    check_val("first_play_y", int'(bola_y), 238);
    check_val("first_play_pad_d", int'(barra_d_y), 200);
    run_ticks(57, 1);
    check_val("pad_e_sat_top", int'(barra_e_y), 0);
    run_ticks(10, 2);
    check_val("pad_e_both_hold", int'(barra_e_y), 0);

    // Random play, then a reset landing on a frame_tick pulse.
    run_ticks(150, 0);
    wait_tick();
    pulse_reset();
    run_ticks(150, 0);

    run_ticks(400, 3);

    t = 0;
    while (m_mode != 2 && t < 6000) begin
      run_ticks(1, 4);
      t++;
    end
    check_val("reached_game_over", m_mode, 2);
    run_ticks(20, 0);
    @(negedge clk_clk);
    check_val("game_over_flag", int'(game_over), 1);
    check_val("score_cap", int'((score_e == 4'd9) || (score_d == 4'd9)), 1);

    @(negedge clk_clk);
    pulse_reset();
    run_ticks(5, 0);
    repeat (3) @(negedge clk_clk);
    check_val("queue_drained", exp_q.size(), 0);
    finish_run();
  end

endmodule

// File: doc/pong_game_engine.md
Name: pong_game_engine

Overview:
- Upstream stage of the Qsys system's VGA monitor port; produces the four 10-bit position inputs (bola_x, bola_y, barra_e_y, barra_d_y) the video core renders.
- Runs Pong physics once per frame tick: paddle motion from the 4 push-buttons, ball motion, wall and paddle bounces, point scoring, serve and game-over sequencing.
- Also exports scores for the LCD path.

Parameters:
- TICK_DIV, 833333, clk_clk cycles per physics tick (50 MHz / 60 Hz).
- SCR_W, 640, screen width in pixels.
- SCR_H, 480, screen height in pixels.
- BALL_SZ, 8, ball side in pixels.
- PAD_H, 80, paddle height.
- PAD_W, 8, paddle width.
- PAD_E_X, 16, left paddle x (left edge).
- PAD_D_X, 616, right paddle x (left edge).
- PAD_SPD, 4, paddle pixels per tick.
- BALL_SPD, 2, ball pixels per tick per axis.
- SERVE_TICKS, 60, ticks waited in SERVE.
- MAX_SCORE, 9, points that end the game.

Ports:
- clk_clk  in  1  system clock.
- reset_reset  in  1  synchronous active-high reset.
- buttons_export  in  4  raw KEYs, active-low: [0] left up, [1] left down, [2] right up, [3] right down.
- bola_x  out  10  ball top-left x.
- bola_y  out  10  ball top-left y.
- barra_e_y  out  10  left paddle top y.
- barra_d_y  out  10  right paddle top y.
- score_e  out  4  left score.
- score_d  out  4  right score.
- game_over  out  1  high in OVER state.
- frame_tick  out  1  one-cycle pulse per physics tick.

Behaviour:
Clocking and reset:
- One clock; reset is synchronous and active-high.
- All outputs are registered and update only on the cycle after frame_tick.

Reset values:
- bola_x=316, bola_y=236.
- barra_e_y = barra_d_y = 200.
- Scores 0, game_over=0, frame_tick=0.
- Velocity vx=+BALL_SPD, vy=+BALL_SPD; state SERVE; serve counter 0; tick counter 0.

Button input:
- buttons_export goes through a 2-flop synchronizer, then is inverted to pressed=1.

Tick generator:
- Counter 0..TICK_DIV-1; frame_tick asserted when the counter wraps.

Paddles (every tick, all states except OVER):
- up-only: y -= PAD_SPD, clamped at 0.
- down-only: y += PAD_SPD, clamped at SCR_H-PAD_H (400).
- both or neither pressed: hold.

FSM (pong_pkg::state_t):
- SERVE: ball held at centre (316,236). Count ticks. At SERVE_TICKS → PLAY.
- PLAY, per tick, using 11-bit signed arithmetic for nx = x+vx and ny = y+vy:
  - Vertical: ny<0 → y=0, vy=+BALL_SPD. ny > SCR_H-BALL_SZ → y=SCR_H-BALL_SZ, vy=-BALL_SPD. Otherwise y=ny.
  - Left paddle hit: vx<0, nx ≤ PAD_E_X+PAD_W, nx+BALL_SZ > PAD_E_X, and vertical overlap (by+BALL_SZ > barra_e_y and by < barra_e_y+PAD_H, using current values) → x=PAD_E_X+PAD_W, vx=+BALL_SPD.
  - Right paddle hit: mirror of the left, against PAD_D_X → x=PAD_D_X-BALL_SZ, vx=-BALL_SPD.
  - Left miss: nx<0 → score_d+1, next serve vx=-BALL_SPD.
  - Right miss: nx > SCR_W-BALL_SZ → score_e+1, next serve vx=+BALL_SPD.
  - After a miss: if the new score = MAX_SCORE → OVER, else → SERVE with counter cleared.
  - Simultaneous vertical and horizontal events in one tick are both applied; a paddle hit takes priority over a miss.
- OVER: all positions frozen, game_over=1. Only reset exits.

Timing and boundaries:
- Reset asserted mid-tick or mid-play restores all reset values on the next edge.
- Scores never exceed MAX_SCORE.

Decomposition:
- Package pong_pkg:
  - state_t enum {SERVE, PLAY, OVER}.
  - Screen, paddle and ball geometry constants as defaults.
  - Button bit index constants.
- Sub-module pong_tick_gen (TICK_DIV counter → frame_tick).
- Physics and FSM stay in pong_game_engine.

Test Plan:
- All bench scenarios use TICK_DIV=4 and SERVE_TICKS=2.
- Reset then 3 ticks → ball leaves centre: after the first PLAY tick bola=(318,238); paddles 200.
- Hold button[0] low for 60 ticks → barra_e_y decrements by 4 per tick, saturates at 0. Then hold [0] and [1] low together → stays at 0.
- Force ball near the top with vy<0 (y=1) → next tick y=0, vy=+2; the tick after, y=2.
- barra_e_y=200, ball approaching left with y=220, x=25 → x clamps to 24, vx=+2, score unchanged.
- Paddle moved to 0, ball at y=300 going left → passes x<0: score_d=1, state SERVE, ball at (316,236), serve vx=-2.
- Score_d at 8 then one more left miss → score_d=9, game_over=1, positions frozen for 20 ticks. reset_reset=1 for one cycle → all reset values restored.
